// File: rtl/lock_pkg.sv
// rtl/lock_pkg.sv - shared state encoding, digit count and BCD check for the lock block
package lock_pkg;

  typedef enum logic [2:0] {
    LOCKED   = 3'd0,
    UNLOCKED = 3'd1,
    CHANGE   = 3'd2,
    LOCKOUT  = 3'd3
  } lock_state_e;

  localparam int NUM_DIGITS = 4;

  // True when every nibble of a 4-digit entry is a legal decimal digit.
  function automatic logic is_bcd4(input logic [15:0] digits);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digits[4*i +: 4] > 4'd9) ok = 1'b0;
    end
    return ok;
  endfunction

endpackage

// File: rtl/lock_timer.sv
// rtl/lock_timer.sv - loadable down-counter; expired is high while the count is zero
module lock_timer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/lock_controller.sv
// rtl/lock_controller.sv - keypad code checker: unlock window, attempt counting, lockout, code change
module lock_controller
  import lock_pkg::*;
#(
  parameter logic [15:0] DEFAULT_CODE   = 16'h0358,
  parameter int          MAX_TRIES      = 3,
  parameter int          UNLOCK_CYCLES  = 1000,
  parameter int          LOCKOUT_CYCLES = 5000,
  parameter int          ATT_W          = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [15:0]      password,
  input  logic             enter_out,
  input  logic             delete_out,
  input  logic [2:0]       counter,
  input  logic             change_req,
  output logic             clear_entry,
  output logic             unlock,
  output logic             fail_pulse,
  output logic             alarm,
  output logic [ATT_W-1:0] attempts,
  output logic [2:0]       state
);

  localparam int TIMER_MAX = (UNLOCK_CYCLES > LOCKOUT_CYCLES) ? UNLOCK_CYCLES : LOCKOUT_CYCLES;
  localparam int TIMER_W   = $clog2(TIMER_MAX);
  localparam logic [ATT_W-1:0] ATT_MAX = ATT_W'(MAX_TRIES);

  lock_state_e        cur_state, nxt_state;
  logic [15:0]        code;
  logic               enter_q, enter_prev, delete_q, delete_prev, change_q, change_prev;
  logic               enter_edge, delete_edge, change_edge, submit;
  logic               entry_valid, match;
  logic [ATT_W-1:0]   att_inc, att_nxt;
  logic               clear_nxt, fail_nxt, code_load;
  logic               timer_load, timer_expired;
  logic [TIMER_W-1:0] timer_value;

  assign enter_edge  = enter_q & ~enter_prev;
  assign delete_edge = delete_q & ~delete_prev;
  assign change_edge = change_q & ~change_prev;
  // A delete arriving with an enter cancels the submission.
  assign submit      = enter_edge & ~delete_edge;

  assign entry_valid = (counter == 3'(NUM_DIGITS)) && is_bcd4(password);
  assign match       = entry_valid && (password == code);
  assign att_inc     = (attempts >= ATT_MAX) ? ATT_MAX : attempts + 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cur_state   <= LOCKED;
      code        <= DEFAULT_CODE;
      attempts    <= '0;
      clear_entry <= 1'b0;
      fail_pulse  <= 1'b0;
      enter_q     <= 1'b0;
      enter_prev  <= 1'b0;
      delete_q    <= 1'b0;
      delete_prev <= 1'b0;
      change_q    <= 1'b0;
      change_prev <= 1'b0;
    end else begin
      cur_state   <= nxt_state;
      attempts    <= att_nxt;
      clear_entry <= clear_nxt;
      fail_pulse  <= fail_nxt;
      if (code_load) code <= password;
      enter_q     <= enter_out;
      enter_prev  <= enter_q;
      delete_q    <= delete_out;
      delete_prev <= delete_q;
      change_q    <= change_req;
      change_prev <= change_q;
    end
  end

  always_comb begin
    nxt_state = cur_state;
    unique case (cur_state)
      LOCKED: begin
        if (submit) begin
          if (match)                   nxt_state = UNLOCKED;
          else if (att_inc == ATT_MAX) nxt_state = LOCKOUT;
        end
      end
      UNLOCKED: begin
        if (change_edge)        nxt_state = CHANGE;
        else if (submit)        nxt_state = LOCKED;
        else if (timer_expired) nxt_state = LOCKED;
      end
      CHANGE: begin
        if (delete_edge)                 nxt_state = LOCKED;
        else if (submit && entry_valid)  nxt_state = LOCKED;
      end
      LOCKOUT: begin
        if (timer_expired) nxt_state = LOCKED;
      end
      default: nxt_state = LOCKED;
    endcase
  end

  always_comb begin
    clear_nxt = 1'b0;
    fail_nxt  = 1'b0;
    att_nxt   = attempts;
    code_load = 1'b0;
    unique case (cur_state)
      LOCKED: begin
        if (delete_edge) begin
          clear_nxt = 1'b1;
        end else if (submit) begin
          clear_nxt = 1'b1;
          if (match) begin
            att_nxt = '0;
          end else begin
            fail_nxt = 1'b1;
            att_nxt  = att_inc;
          end
        end
      end
      UNLOCKED: begin
        if (change_edge || submit) clear_nxt = 1'b1;
      end
      CHANGE: begin
        if (delete_edge) begin
          clear_nxt = 1'b1;
        end else if (submit) begin
          clear_nxt = 1'b1;
          if (entry_valid) code_load = 1'b1;
          else             fail_nxt  = 1'b1;
        end
      end
      LOCKOUT: begin
        if (timer_expired) att_nxt = '0;
      end
      default: ;
    endcase
  end

  // The timer is reloaded on every state change; only the timed states use it.
  always_comb begin
    timer_load = (nxt_state != cur_state);
    unique case (nxt_state)
      UNLOCKED: timer_value = TIMER_W'(UNLOCK_CYCLES - 1);
      LOCKOUT:  timer_value = TIMER_W'(LOCKOUT_CYCLES - 1);
      default:  timer_value = '0;
    endcase
  end

  lock_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timer_load),
    .load_value(timer_value),
    .expired   (timer_expired)
  );

  assign unlock = (cur_state == UNLOCKED);
  assign alarm  = (cur_state == LOCKOUT);
  assign state  = cur_state;

endmodule
